// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: branch funct3 encodings and default datapath width.
package riscv_pkg;

   localparam int DEFAULT_XLEN = 32;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation: maps funct3 and ALU compare flags to a taken flag.
module branch_cond
   import riscv_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       less_signed,
   input  logic       less_unsigned,
   output logic       cond
);

   // Decode the six RV32I branch types; reserved encodings never take.
   always_comb begin
      cond = 1'b0;
      case (funct3)
         F3_BEQ:  cond = zero;
         F3_BNE:  cond = ~zero;
         F3_BLT:  cond = less_signed;
         F3_BGE:  cond = ~less_signed;
         F3_BLTU: cond = less_unsigned;
         F3_BGEU: cond = ~less_unsigned;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] count_reg;

   // Increment on request unless already saturated.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + CNT_WIDTH'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter stage: owns the PC, selects the next PC from branch/jump
// controls, traps misaligned targets and keeps branch statistics.
module next_pc_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN      = DEFAULT_XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [XLEN-1:0] TRAP_PC   = XLEN'(32'h0000_0100),
   parameter int              CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 branch,
   input  logic                 jump,
   input  logic                 jalr,
   input  logic [2:0]           funct3,
   input  logic                 zero,
   input  logic                 less_signed,
   input  logic                 less_unsigned,
   input  logic [XLEN-1:0]      imm,
   input  logic [XLEN-1:0]      rs1_value,
   output logic [XLEN-1:0]      pc,
   output logic [XLEN-1:0]      pc_plus4,
   output logic                 redirect,
   output logic                 misaligned,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] taken_count
);

   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pc_next;
   logic            redirect_reg;
   logic            misaligned_reg;

   logic            cond;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] rel_target;
   logic [XLEN-1:0] target;
   logic            taken;
   logic            trap;

   branch_cond u_branch_cond (
      .funct3        (funct3),
      .zero          (zero),
      .less_signed   (less_signed),
      .less_unsigned (less_unsigned),
      .cond          (cond)
   );

   assign pc_plus4   = pc_reg + XLEN'(4);
   assign jalr_sum   = rs1_value + imm;
   assign rel_target = pc_reg + imm;
   assign taken      = jalr | jump | (branch & cond);

   // Target priority: jalr over jump over taken branch; sequential otherwise.
   // JALR clears bit 0 of the sum; only bit 1 can then cause a trap.
   always_comb begin
      target  = pc_plus4;
      if (jalr) begin
         target = jalr_sum & ~XLEN'(1);
      end else if (jump || (branch && cond)) begin
         target = rel_target;
      end
      trap    = taken & target[1];
      pc_next = trap ? TRAP_PC : target;
   end

   // PC and one-cycle status pulses; a stall holds the PC but drops pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_reg         <= RESET_PC;
         redirect_reg   <= 1'b0;
         misaligned_reg <= 1'b0;
      end else if (enable) begin
         pc_reg         <= pc_next;
         redirect_reg   <= taken;
         misaligned_reg <= trap;
      end else begin
         redirect_reg   <= 1'b0;
         misaligned_reg <= 1'b0;
      end
   end

   // Branch count includes branches overridden by jump/jalr; taken count does not.
   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_branch_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (enable & branch),
      .count (branch_count)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_taken_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (enable & branch & cond & ~jump & ~jalr),
      .count (taken_count)
   );

   assign pc         = pc_reg;
   assign redirect   = redirect_reg;
   assign misaligned = misaligned_reg;

endmodule
